// File: rtl/jstk_pkg.sv
// Shared constants for the two-joystick poll arbiter: state encoding,
// SPI command prefix and receive data width.
package jstk_pkg;

    localparam int DATA_W = 40;
    localparam logic [5:0] CMD_PREFIX = 6'b100000;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/jstk_cycle_timer.sv
// Loadable down-counter that saturates at zero; zero is high on the last
// cycle of a programmed interval (load value N-1 gives N cycles).
module jstk_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/jstk_poll_arbiter.sv
// Round-robin poller sharing one SPI engine between two joysticks; each
// poll selects a slave, starts the engine and captures its reply.
module jstk_poll_arbiter
    import jstk_pkg::*;
#(
    parameter int SETUP_CYC   = 1500,
    parameter int GAP_CYC     = 2500,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [1:0]        en,
    input  logic [3:0]        led,
    output logic              eng_start,
    output logic [7:0]        eng_din,
    input  logic              eng_done,
    input  logic [DATA_W-1:0] eng_dout,
    output logic [1:0]        ss_n,
    output logic [DATA_W-1:0] jstk0_data,
    output logic [DATA_W-1:0] jstk1_data,
    output logic [1:0]        upd,
    output logic [1:0]        err,
    output logic              overrun,
    output logic              busy,
    output logic [2:0]        state_dbg
);

    localparam int CW = $clog2(max3(SETUP_CYC, GAP_CYC, TIMEOUT_CYC)) + 1;

    logic [2:0]    state, state_nxt;
    logic          sel, ptr, pending;
    logic          tmr_zero, tmr_load;
    logic [CW-1:0] tmr_val;
    logic          active;

    // Engine link: eng_start is a one-cycle request, the engine answers
    // with a one-cycle eng_done; there is no back-pressure in either
    // direction, and a done seen outside WAIT carries no meaning.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if ((tick || pending) && (en != 2'b00)) state_nxt = ST_SETUP;
            ST_SETUP: if (tmr_zero) state_nxt = ST_START;
            ST_START: state_nxt = ST_WAIT;
            ST_WAIT:  if (eng_done || tmr_zero) state_nxt = ST_HOLD;
            ST_HOLD:  if (tmr_zero) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // The timer is reloaded on every state entry with that state's length.
    always_comb begin
        tmr_load = (state_nxt != state);
        case (state_nxt)
            ST_SETUP: tmr_val = CW'(SETUP_CYC - 1);
            ST_WAIT:  tmr_val = CW'(TIMEOUT_CYC - 1);
            ST_HOLD:  tmr_val = CW'(GAP_CYC - 1);
            default:  tmr_val = '0;
        endcase
    end

    jstk_cycle_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sel        <= 1'b0;
            ptr        <= 1'b0;
            pending    <= 1'b0;
            overrun    <= 1'b0;
            upd        <= 2'b00;
            err        <= 2'b00;
            jstk0_data <= '0;
            jstk1_data <= '0;
        end else begin
            state <= state_nxt;
            upd   <= 2'b00;
            if (state == ST_IDLE && state_nxt == ST_SETUP) begin
                sel     <= en[ptr] ? ptr : ~ptr;
                pending <= 1'b0;
            end else if (state != ST_IDLE && tick && en != 2'b00) begin
                if (!pending) pending <= 1'b1;
                else          overrun <= 1'b1;
            end
            // Done wins over a timeout landing on the same cycle.
            if (state == ST_WAIT && eng_done) begin
                if (sel) jstk1_data <= eng_dout;
                else     jstk0_data <= eng_dout;
                upd[sel] <= 1'b1;
                err[sel] <= 1'b0;
            end else if (state == ST_WAIT && tmr_zero) begin
                err[sel] <= 1'b1;
            end
            if (state == ST_HOLD && tmr_zero) ptr <= ~sel;
        end
    end

    assign active    = (state == ST_SETUP) || (state == ST_START) || (state == ST_WAIT);
    assign ss_n      = active ? (sel ? 2'b01 : 2'b10) : 2'b11;
    assign eng_din   = active ? {CMD_PREFIX, (sel ? led[3:2] : led[1:0])} : 8'h00;
    assign eng_start = (state == ST_START);
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_jstk_poll_arbiter.sv
// Directed bench for jstk_poll_arbiter with short SETUP/GAP/TIMEOUT values.
module tb_jstk_poll_arbiter;

    logic        clk;
    logic        rst;
    logic        tick;
    logic [1:0]  en;
    logic [3:0]  led;
    logic        eng_start;
    logic [7:0]  eng_din;
    logic        eng_done;
    logic [39:0] eng_dout;
    logic [1:0]  ss_n;
    logic [39:0] jstk0_data;
    logic [39:0] jstk1_data;
    logic [1:0]  upd;
    logic [1:0]  err;
    logic        overrun;
    logic        busy;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int ss0_low_cnt = 0;
    int start_before;
    int ss0_before;

    jstk_poll_arbiter #(
        .SETUP_CYC   (4),
        .GAP_CYC     (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .en         (en),
        .led        (led),
        .eng_start  (eng_start),
        .eng_din    (eng_din),
        .eng_done   (eng_done),
        .eng_dout   (eng_dout),
        .ss_n       (ss_n),
        .jstk0_data (jstk0_data),
        .jstk1_data (jstk1_data),
        .upd        (upd),
        .err        (err),
        .overrun    (overrun),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (eng_start === 1'b1) start_cnt <= start_cnt + 1;
        if (ss_n[0] === 1'b0)   ss0_low_cnt <= ss0_low_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (eng_start !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("start_seen", eng_start, 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            step();
            n++;
        end
        check("idle_reached", busy, 1'b0);
    endtask

    // Called in the START cycle; raises done during WAIT cycle number 'delay'.
    task automatic run_engine(input int delay, input logic [39:0] data);
        step();
        repeat (delay - 1) step();
        eng_done = 1'b1;
        eng_dout = data;
        step();
        eng_done = 1'b0;
        eng_dout = '0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; en = 2'b11; led = 4'b1001;
        eng_done = 1'b0; eng_dout = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        check("rst_ss_n", ss_n, 2'b11);
        check("rst_start", eng_start, 1'b0);
        check("rst_din", eng_din, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_state", state_dbg, 3'd0);
        check("rst_flags", {upd, err, overrun}, 5'b0);
        check("rst_data0", jstk0_data, 40'h0);

        // Joystick 0 first, start 5 cycles after the tick.
        pulse_tick();
        check("s1_ss_n", ss_n, 2'b10);
        check("s1_din", eng_din, 8'h81);
        repeat (3) step();
        check("s1_no_start_early", eng_start, 1'b0);
        step();
        check("s1_start_latency", eng_start, 1'b1);
        run_engine(10, 40'hA5);
        check("s1_upd", upd, 2'b01);
        check("s1_data0", jstk0_data, 40'hA5);
        step();
        check("s1_upd_one_cycle", upd, 2'b00);
        wait_idle();

        // Round-robin to joystick 1.
        pulse_tick();
        check("s1b_ss_n", ss_n, 2'b01);
        check("s1b_din", eng_din, 8'h82);
        wait_start();
        run_engine(10, 40'h5A_1234);
        check("s1b_upd", upd, 2'b10);
        check("s1b_data1", jstk1_data, 40'h5A_1234);
        check("s1b_data0_kept", jstk0_data, 40'hA5);
        wait_idle();

        // Only joystick 1 enabled: served every time, ss_n[0] never low.
        en = 2'b10;
        ss0_before = ss0_low_cnt;
        for (int i = 1; i <= 3; i++) begin
            pulse_tick();
            check("s2_ss_n", ss_n, 2'b01);
            wait_start();
            run_engine(3, 40'(i * 17));
            check("s2_upd", upd, 2'b10);
            check("s2_data1", jstk1_data, 40'(i * 17));
            wait_idle();
        end
        check("s2_ss0_never_low", 64'(ss0_low_cnt - ss0_before), 64'd0);

        // Timeout on joystick 0.
        en = 2'b11;
        pulse_tick();
        check("s3_ss_n", ss_n, 2'b10);
        wait_start();
        repeat (16) step();
        check("s3_still_wait", state_dbg, 3'd3);
        check("s3_err_not_yet", err, 2'b00);
        step();
        check("s3_err_set", err, 2'b01);
        check("s3_no_upd", upd, 2'b00);
        check("s3_data_kept", jstk0_data, 40'hA5);
        step();
        check("s3_no_upd_later", upd, 2'b00);
        wait_idle();

        // Joystick 1: done on the timeout cycle counts as done.
        pulse_tick();
        wait_start();
        run_engine(16, 40'h44);
        check("s3b_upd", upd, 2'b10);
        check("s3b_data1", jstk1_data, 40'h44);
        check("s3b_err", err, 2'b01);
        wait_idle();

        // Joystick 0 succeeds and clears its error.
        pulse_tick();
        wait_start();
        run_engine(3, 40'h55);
        check("s3c_err_clear", err, 2'b00);
        check("s3c_data0", jstk0_data, 40'h55);
        wait_idle();

        // Done while idle is ignored.
        eng_done = 1'b1; eng_dout = 40'hDEAD;
        step();
        eng_done = 1'b0; eng_dout = '0;
        check("idle_done_data0", jstk0_data, 40'h55);
        check("idle_done_data1", jstk1_data, 40'h44);
        check("idle_done_upd", upd, 2'b00);
        check("idle_done_busy", busy, 1'b0);

        // Two ticks in WAIT: pending then overrun, exactly one extra poll.
        start_before = start_cnt;
        pulse_tick();
        wait_start();
        step();
        pulse_tick();
        check("s4_no_overrun_yet", overrun, 1'b0);
        pulse_tick();
        check("s4_overrun", overrun, 1'b1);
        eng_done = 1'b1; eng_dout = 40'h66;
        step();
        eng_done = 1'b0; eng_dout = '0;
        check("s4_upd1", upd, 2'b10);
        wait_idle();
        wait_start();
        check("s4_extra_ss_n", ss_n, 2'b10);
        run_engine(2, 40'h77);
        check("s4_upd0", upd, 2'b01);
        check("s4_data0", jstk0_data, 40'h77);
        wait_idle();
        repeat (30) step();
        check("s4_stays_idle", busy, 1'b0);
        check("s4_two_starts", 64'(start_cnt - start_before), 64'd2);

        // Reset in the middle of WAIT.
        pulse_tick();
        wait_start();
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("s5_ss_n", ss_n, 2'b11);
        check("s5_busy", busy, 1'b0);
        check("s5_start_din", {eng_start, eng_din}, 9'h0);
        check("s5_flags", {upd, err, overrun}, 5'b0);
        check("s5_data0", jstk0_data, 40'h0);
        check("s5_data1", jstk1_data, 40'h0);
        eng_done = 1'b1; eng_dout = 40'hFF;
        step();
        eng_done = 1'b0; eng_dout = '0;
        check("s5_late_done_data", {jstk0_data, jstk1_data}, 80'h0);
        check("s5_late_done_upd", upd, 2'b00);

        // Tick with nothing enabled is dropped entirely.
        en = 2'b00;
        pulse_tick();
        check("s6_busy", busy, 1'b0);
        en = 2'b11;
        repeat (3) step();
        check("s6_no_pending", busy, 1'b0);
        check("s6_no_overrun", overrun, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
